// File: rtl/pcm_tdm_frame_dec.sv
// PCM receive frame decoder.
// Shifts in a serial PCM stream (MSB first), locks onto the frame alignment
// word in slot 0 using a HUNT/PRESYNC/SYNC state machine, and emits each data
// slot as a parallel word tagged with its channel number once in SYNC.
module pcm_tdm_frame_dec #(
  parameter int                WORD_W   = 8,
  parameter int                CHANNELS = 4,
  parameter logic [WORD_W-1:0] FAS      = 8'h9B,
  parameter int                CONFIRM  = 2,
  parameter int                MISS_MAX = 3,
  localparam int               CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [CH_W-1:0]   data_chan,
  output logic              frame_start,
  output logic              in_sync,
  output logic              sync_lost
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int SLOT_W = $clog2(CHANNELS + 1);
  localparam int CONF_W = $clog2(CONFIRM + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CONF_W-1:0]   confirm_q, confirm_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [WORD_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic [CH_W-1:0]     data_chan_q, data_chan_d;
  logic                frame_start_q, frame_start_d;
  logic                in_sync_q, in_sync_d;
  logic                sync_lost_q, sync_lost_d;

  // The word as it stands after shifting in the current bit.
  logic [WORD_W-1:0]   word_w;
  logic                fas_hit;
  logic                word_done;

  assign word_w    = {shift_q[WORD_W-2:0], serial_in};
  assign fas_hit   = (word_w == FAS);
  assign word_done = (bit_cnt_q == BIT_LAST);

  // Next-state logic: everything advances only on a consumed bit; pulses self-clear.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    slot_d        = slot_q;
    confirm_d     = confirm_q;
    miss_d        = miss_q;
    data_out_d    = data_out_q;
    data_chan_d   = data_chan_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_lost_d   = 1'b0;

    if (bit_en) begin
      shift_d = word_w;
      if (state_q == HUNT) begin
        // Sliding search: the alignment word just ended, so the next bit opens slot 1.
        if (fas_hit) begin
          state_d   = PRESYNC;
          bit_cnt_d = '0;
          slot_d    = SLOT_W'(1);
          confirm_d = '0;
        end
      end else begin
        bit_cnt_d = word_done ? '0 : bit_cnt_q + BIT_W'(1);
        if (word_done) begin
          slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
          if (slot_q == '0) begin
            if (state_q == PRESYNC) begin
              if (fas_hit) begin
                confirm_d = confirm_q + CONF_W'(1);
                if (confirm_q == CONF_LAST) begin
                  state_d = SYNC;
                  miss_d  = '0;
                end
              end else begin
                state_d   = HUNT;
                bit_cnt_d = '0;
                slot_d    = '0;
                confirm_d = '0;
                miss_d    = '0;
              end
            end else if (fas_hit) begin
              miss_d        = '0;
              frame_start_d = 1'b1;
            end else if (miss_q == MISS_LAST) begin
              state_d     = HUNT;
              sync_lost_d = 1'b1;
              bit_cnt_d   = '0;
              slot_d      = '0;
              confirm_d   = '0;
              miss_d      = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else if (state_q == SYNC) begin
            data_out_d   = word_w;
            data_chan_d  = CH_W'(slot_q - SLOT_W'(1));
            data_valid_d = 1'b1;
          end
        end
      end
    end

    in_sync_d = (state_d == SYNC);
  end

  // State and registered outputs; reset aborts any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      slot_q        <= '0;
      confirm_q     <= '0;
      miss_q        <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      data_chan_q   <= '0;
      frame_start_q <= 1'b0;
      in_sync_q     <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      confirm_q     <= confirm_d;
      miss_q        <= miss_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      data_chan_q   <= data_chan_d;
      frame_start_q <= frame_start_d;
      in_sync_q     <= in_sync_d;
      sync_lost_q   <= sync_lost_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign data_chan   = data_chan_q;
  assign frame_start = frame_start_q;
  assign in_sync     = in_sync_q;
  assign sync_lost   = sync_lost_q;

endmodule

// File: tb/tb_pcm_tdm_frame_dec.sv
// Testbench for pcm_tdm_frame_dec: directed frame scenarios plus randomized
// frames and bit gaps, checked cycle by cycle against a position-based model.
module tb_pcm_tdm_frame_dec;

  localparam int         WORD_W   = 8;
  localparam int         CHANNELS = 4;
  localparam logic [7:0] FAS      = 8'h9B;
  localparam int         CONFIRM  = 2;
  localparam int         MISS_MAX = 3;
  localparam int         FRAME_SLOTS = CHANNELS + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [1:0] data_chan;
  logic       frame_start;
  logic       in_sync;
  logic       sync_lost;

  pcm_tdm_frame_dec #(
    .WORD_W(WORD_W), .CHANNELS(CHANNELS), .FAS(FAS),
    .CONFIRM(CONFIRM), .MISS_MAX(MISS_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
    .data_out(data_out), .data_valid(data_valid), .data_chan(data_chan),
    .frame_start(frame_start), .in_sync(in_sync), .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dv_seen = 0;
  int sl_seen = 0;
  int gap_mode = 0;

  // Reference model: tracks the bit position of the last accepted alignment
  // word and derives slot numbers arithmetically from distance to it.
  int   m_mode;     // 0 hunting, 1 confirming, 2 locked
  int   m_n;        // bits consumed since reset
  int   m_anchor;   // bit index where the locking alignment word ended
  int   m_good;
  int   m_bad;
  bit   m_hist[$];  // most recent WORD_W bits, oldest first
  logic [7:0] e_dout;
  logic [1:0] e_chan;
  logic e_dv, e_fs, e_sl, e_sync;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < WORD_W; i++) m_hist.push_back(1'b0);
    m_mode = 0; m_n = 0; m_anchor = 0; m_good = 0; m_bad = 0;
    e_dout = '0; e_chan = '0;
    e_dv = 0; e_fs = 0; e_sl = 0; e_sync = 0;
  endtask

  task automatic model_step(input bit b);
    logic [7:0] w;
    int n, d, slot;
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    w = '0;
    for (int i = 0; i < WORD_W; i++) w = (w << 1) | 8'(m_hist[i]);
    n = m_n;
    m_n++;
    e_dv = 0; e_fs = 0; e_sl = 0;
    if (m_mode == 0) begin
      if (w == FAS) begin
        m_mode = 1; m_anchor = n; m_good = 0;
      end
    end else begin
      d = n - m_anchor;
      if (d % WORD_W == 0) begin
        slot = (d / WORD_W) % FRAME_SLOTS;
        if (slot == 0) begin
          if (m_mode == 1) begin
            if (w == FAS) begin
              m_good++;
              if (m_good == CONFIRM) begin m_mode = 2; m_bad = 0; end
            end else m_mode = 0;
          end else begin
            if (w == FAS) begin
              m_bad = 0; e_fs = 1;
            end else begin
              m_bad++;
              if (m_bad == MISS_MAX) begin m_mode = 0; e_sl = 1; end
            end
          end
        end else if (m_mode == 2) begin
          e_dv = 1; e_dout = w; e_chan = 2'(slot - 1);
        end
      end
    end
    e_sync = (m_mode == 2);
  endtask

  task automatic compare_all();
    check("data_valid", 32'(data_valid), 32'(e_dv));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("sync_lost", 32'(sync_lost), 32'(e_sl));
    check("in_sync", 32'(in_sync), 32'(e_sync));
    check("data_out", 32'(data_out), 32'(e_dout));
    check("data_chan", 32'(data_chan), 32'(e_chan));
    if (data_valid) dv_seen++;
    if (sync_lost) sl_seen++;
  endtask

  // One clock: drive inputs, let the edge happen, then compare after it.
  task automatic cycle(input logic en, input logic b);
    bit_en = en;
    serial_in = b;
    @(posedge clk);
    #1;
    if (en) model_step(b);
    else begin e_dv = 0; e_fs = 0; e_sl = 0; end
    compare_all();
  endtask

  task automatic send_bit(input logic b);
    int idle;
    idle = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
    for (int i = 0; i < idle; i++) cycle(1'b0, 1'($urandom));
    cycle(1'b1, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_std_frame(input logic [7:0] fas_word);
    send_byte(fas_word);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bit_en = 1'b0;
    #2;
    model_reset();
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_in_sync", 32'(in_sync), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int dv0;
  logic [7:0] rnd;

  initial begin
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: reset mid-stream, then a long run of zeros never locks
    for (int i = 0; i < 13; i++) send_bit(1'($urandom));
    apply_reset();
    dv0 = dv_seen;
    for (int i = 0; i < 100; i++) send_bit(1'b0);
    check("t1_no_data", 32'(dv_seen - dv0), 32'd0);
    check("t1_in_sync", 32'(in_sync), 32'd0);

    // 2: clean frames, lock after the third alignment word
    apply_reset();
    dv0 = dv_seen;
    send_std_frame(FAS); send_std_frame(FAS);
    check("t2_not_yet", 32'(in_sync), 32'd0);
    send_std_frame(FAS);
    check("t2_locked", 32'(in_sync), 32'd1);
    check("t2_frame3_words", 32'(dv_seen - dv0), 32'd4);
    send_std_frame(FAS); send_std_frame(FAS);
    check("t2_total_words", 32'(dv_seen - dv0), 32'd12);

    // 3: two bad alignment words tolerated, the third drops sync
    dv0 = dv_seen;
    sl_seen = 0;
    send_std_frame(8'h00); send_std_frame(8'h00);
    check("t3_still_sync", 32'(in_sync), 32'd1);
    check("t3_data_kept", 32'(dv_seen - dv0), 32'd8);
    dv0 = dv_seen;
    send_std_frame(8'h00);
    check("t3_lost_pulse", 32'(sl_seen), 32'd1);
    check("t3_no_data", 32'(dv_seen - dv0), 32'd0);
    check("t3_out_of_sync", 32'(in_sync), 32'd0);

    // 4: same stream with a bit strobe every third cycle
    apply_reset();
    gap_mode = 1;
    dv0 = dv_seen;
    for (int f = 0; f < 5; f++) send_std_frame(FAS);
    check("t4_gapped_words", 32'(dv_seen - dv0), 32'd12);
    gap_mode = 0;

    // 5: junk prefix and a broken second frame, then relock
    apply_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    send_std_frame(FAS);
    send_std_frame(8'h00);
    for (int f = 0; f < 7; f++) send_std_frame(FAS);
    check("t5_relocked", 32'(in_sync), 32'd1);

    // 6: reset on bit 5 of slot 2 while locked; full confirmation again
    send_byte(FAS); send_byte(8'h11);
    for (int i = 7; i > 2; i--) send_bit(rnd[0] ^ 1'b0 | (8'h22 >> i) & 1'b1);
    apply_reset();
    send_std_frame(FAS); send_std_frame(FAS);
    check("t6_not_yet", 32'(in_sync), 32'd0);
    send_std_frame(FAS);
    check("t6_locked", 32'(in_sync), 32'd1);

    // Random data, random gaps, occasional corrupted alignment words
    gap_mode = 2;
    for (int f = 0; f < 30; f++) begin
      rnd = ($urandom_range(0, 5) == 0) ? 8'($urandom) : FAS;
      send_byte(rnd);
      for (int s = 0; s < CHANNELS; s++) send_byte(8'($urandom));
    end
    gap_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial rnd = 8'h00;

endmodule
